gates_bist: RTL and testbench
=============================

# gates_bist

Self-checking stimulus generator and response checker for the simple gate library (inverter, 2-input AND, 2-input NAND). It drives the gate-under-test inputs from two LFSRs and checks the gate outputs against internally computed expected values. Results are reported as a pass flag, an error count and the index of the first failing vector. It sits opposite the gate top in a hardware-only bench: it drives what the external C testbench otherwise drives, and checks what that testbench otherwise checks, so gates can be tested on FPGA or in Verilator without C-side checking.

## Interface

Parameters:
- WIDTH, 64, gate data width; legal range 1..64.
- NUM_VECTORS, 256, vectors per run; legal range 1..65535.
- LATENCY, 0, cycles from in1/in2 to valid gate outputs; legal range 0..7.
- SEED1, 64'h0123_4567_89AB_CDEF, LFSR1 seed. A value of 0 is replaced by 1.
- SEED2, 64'hFEDC_BA98_7654_3210, LFSR2 seed. A value of 0 is replaced by 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin a run. Sampled only in IDLE or DONE.
- inj  in  1  error injection: inverts bit 0 of expected out_inv for the vector issued this cycle.
- in1  out  WIDTH  stimulus to the gates, equal to LFSR1[WIDTH-1:0].
- in2  out  WIDTH  stimulus to the gates, equal to LFSR2[WIDTH-1:0].
- out_inv, out_and2, out_nand2  in  WIDTH each  gate responses.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  meaningful when done=1; set to 1 iff err_count==0.
- err_count  out  16  number of mismatching vectors; saturates at 16'hFFFF.
- first_fail_idx  out  16  index of the first mismatching vector; 16'hFFFF if there was none.

## Operation

- The FSM has four states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN, and DONE→RUN, when start=1.
  - RUN→DRAIN after the vector with index NUM_VECTORS-1 is issued. If LATENCY=0, RUN goes directly to DONE.
  - DRAIN→DONE after LATENCY cycles.
  - start is ignored in RUN and DRAIN.
- LFSRs: both are 64-bit Fibonacci, next = {q[62:0], q[63]^q[62]^q[60]^q[59]}.
  - On entry to RUN, both are loaded from their seeds. Vector 0 is the seeds themselves.
  - Each RUN cycle advances both LFSRs one step.
- in1/in2 are driven 0 outside RUN.
- Expected values are computed per vector:
  - inv: ~in1
  - and2: in1&in2
  - nand2: ~(in1&in2)
  - If inj=1, bit 0 of expected inv is flipped.
- Expected values, the vector index and a valid bit pass through a LATENCY-deep shift register.
- Compare: at each cycle where the delayed valid bit is set, all three outputs are compared bitwise to the delayed expected values. Any mismatch counts as one error for that vector.
- Error recording:
  - err_count increments by one per mismatching vector, saturating at 16'hFFFF.
  - first_fail_idx latches the delayed index on the first mismatch only.
- Entry to RUN clears err_count to 0 and first_fail_idx to 16'hFFFF.
- Results (err_count, first_fail_idx, pass) hold stable in DONE until the next start.

## Timing

- Reset values: state=IDLE, in1=0, in2=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=16'hFFFF. LFSRs are loaded with their seeds and the pipeline valid bits are cleared.
- Reset mid-run aborts immediately to the reset values above. No partial results survive the reset.
- Run sequence:
  - start is sampled at edge T0.
  - Vector k appears on in1/in2 during cycle T0+1+k.
  - Vector k is compared at edge T0+1+k+LATENCY.
  - done=1 from cycle T0+1+NUM_VECTORS+LATENCY onwards.
  - busy is high for exactly NUM_VECTORS+LATENCY cycles.
- inj is sampled in the same cycle as the vector it affects. inj has no effect outside RUN.
- Saturating err_count holds 16'hFFFF; first_fail_idx is unaffected by saturation.

## Test plan

- Correct combinational gates, NUM_VECTORS=16, LATENCY=0, start pulse → busy high for 16 cycles, then done=1, pass=1, err_count=0, first_fail_idx=16'hFFFF. Vector 0 has in1=64'h0123_4567_89AB_CDEF and in2=64'hFEDC_BA98_7654_3210.
- Same setup with inj=1 during vector 5 only → err_count=1, first_fail_idx=5, pass=0.
- out_and2 stuck at 0 → err_count equals the number of vectors with (in1&in2)!=0, as computed by the bench model. first_fail_idx equals the first such index.
- Gates behind 2 register stages, LATENCY=2 → busy for 18 cycles, pass=1. The same gates with LATENCY=0 → pass=0.
- rst_n low for one cycle at vector 7 → all outputs return to reset values. The next start repeats vector 0 equal to the seeds, and the run completes with pass=1.
- start held high throughout a run → no restart while busy. On reaching DONE, a new run begins the next cycle and err_count is cleared.

Source files
------------

// File: rtl/gates_bist.sv
// rtl/gates_bist.sv - LFSR stimulus generator and response checker for inv/and2/nand2 gates
module gates_bist #(
    parameter int          WIDTH       = 64,
    parameter int          NUM_VECTORS = 256,
    parameter int          LATENCY     = 0,
    parameter logic [63:0] SEED1       = 64'h0123_4567_89AB_CDEF,
    parameter logic [63:0] SEED2       = 64'hFEDC_BA98_7654_3210
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             inj,
    output logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] out_inv,
    input  logic [WIDTH-1:0] out_and2,
    input  logic [WIDTH-1:0] out_nand2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_fail_idx
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // An all-zero seed would lock the LFSR, so it is forced to 1.
    localparam logic [63:0] SEED1_EFF  = (SEED1 == 64'd0) ? 64'd1 : SEED1;
    localparam logic [63:0] SEED2_EFF  = (SEED2 == 64'd0) ? 64'd1 : SEED2;
    localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
    localparam logic [2:0]  LAST_DRAIN = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    state_t      r_state;
    logic [63:0] r_lfsr1;
    logic [63:0] r_lfsr2;
    logic [15:0] r_idx;
    logic [2:0]  r_drain_cnt;
    logic [15:0] r_err_count;
    logic [15:0] r_first_fail;

    logic             w_run;
    logic [WIDTH-1:0] w_exp_inv;
    logic [WIDTH-1:0] w_exp_and;
    logic [WIDTH-1:0] w_exp_nand;
    logic             w_d_valid;
    logic [WIDTH-1:0] w_d_inv;
    logic [WIDTH-1:0] w_d_and;
    logic [WIDTH-1:0] w_d_nand;
    logic [15:0]      w_d_idx;
    logic             w_mismatch;

    function automatic logic [63:0] lfsr_next(input logic [63:0] q);
        return {q[62:0], q[63] ^ q[62] ^ q[60] ^ q[59]};
    endfunction

    assign w_run      = (r_state == S_RUN);
    assign in1        = w_run ? r_lfsr1[WIDTH-1:0] : '0;
    assign in2        = w_run ? r_lfsr2[WIDTH-1:0] : '0;
    assign w_exp_inv  = ~in1 ^ WIDTH'(inj & w_run);
    assign w_exp_and  = in1 & in2;
    assign w_exp_nand = ~(in1 & in2);

    // Expected values travel alongside the gate pipeline so the compare sees matching data.
    generate
        if (LATENCY == 0) begin : g_nodelay
            assign w_d_valid = w_run;
            assign w_d_inv   = w_exp_inv;
            assign w_d_and   = w_exp_and;
            assign w_d_nand  = w_exp_nand;
            assign w_d_idx   = r_idx;
        end else begin : g_delay
            logic [LATENCY-1:0]            r_pv;
            logic [LATENCY-1:0][WIDTH-1:0] r_pinv;
            logic [LATENCY-1:0][WIDTH-1:0] r_pand;
            logic [LATENCY-1:0][WIDTH-1:0] r_pnand;
            logic [LATENCY-1:0][15:0]      r_pidx;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_pv <= '0;
                end else begin
                    for (int i = LATENCY - 1; i > 0; i--) begin
                        r_pv[i]    <= r_pv[i-1];
                        r_pinv[i]  <= r_pinv[i-1];
                        r_pand[i]  <= r_pand[i-1];
                        r_pnand[i] <= r_pnand[i-1];
                        r_pidx[i]  <= r_pidx[i-1];
                    end
                    r_pv[0]    <= w_run;
                    r_pinv[0]  <= w_exp_inv;
                    r_pand[0]  <= w_exp_and;
                    r_pnand[0] <= w_exp_nand;
                    r_pidx[0]  <= r_idx;
                end
            end

            assign w_d_valid = r_pv[LATENCY-1];
            assign w_d_inv   = r_pinv[LATENCY-1];
            assign w_d_and   = r_pand[LATENCY-1];
            assign w_d_nand  = r_pnand[LATENCY-1];
            assign w_d_idx   = r_pidx[LATENCY-1];
        end
    endgenerate

    assign w_mismatch = w_d_valid && ((out_inv != w_d_inv) || (out_and2 != w_d_and) ||
                                      (out_nand2 != w_d_nand));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_lfsr1      <= SEED1_EFF;
            r_lfsr2      <= SEED2_EFF;
            r_idx        <= 16'd0;
            r_drain_cnt  <= 3'd0;
            r_err_count  <= 16'd0;
            r_first_fail <= 16'hFFFF;
        end else begin
            if (w_mismatch) begin
                if (r_err_count != 16'hFFFF) begin
                    r_err_count <= r_err_count + 16'd1;
                end
                if (r_err_count == 16'd0) begin
                    r_first_fail <= w_d_idx;
                end
            end
            // Placed after the compare so a start always wins the result clear.
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_lfsr1      <= SEED1_EFF;
                        r_lfsr2      <= SEED2_EFF;
                        r_idx        <= 16'd0;
                        r_err_count  <= 16'd0;
                        r_first_fail <= 16'hFFFF;
                    end
                end
                S_RUN: begin
                    r_lfsr1     <= lfsr_next(r_lfsr1);
                    r_lfsr2     <= lfsr_next(r_lfsr2);
                    r_idx       <= r_idx + 16'd1;
                    r_drain_cnt <= 3'd0;
                    if (r_idx == LAST_IDX) begin
                        r_state <= (LATENCY == 0) ? S_DONE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == LAST_DRAIN) begin
                        r_state <= S_DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy           = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done           = (r_state == S_DONE);
    assign pass           = done && (r_err_count == 16'd0);
    assign err_count      = r_err_count;
    assign first_fail_idx = r_first_fail;

endmodule

// File: tb/tb_gates_bist.sv
// tb/tb_gates_bist.sv - directed self-checking bench for gates_bist
module tb_gates_bist;

    localparam logic [63:0] S1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] S2 = 64'hFEDC_BA98_7654_3210;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start0, inj0, and_stuck, startl;
    int   checks = 0;
    int   failures = 0;

    // Combinational gates, optional and2 stuck-at-0 fault
    logic [63:0] a1, a2, ai, aa, an;
    logic        busy0, done0, pass0;
    logic [15:0] err0, ffi0;
    assign ai = ~a1;
    assign aa = and_stuck ? 64'd0 : (a1 & a2);
    assign an = ~(a1 & a2);

    gates_bist #(.WIDTH(64), .NUM_VECTORS(16), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .inj(inj0), .in1(a1), .in2(a2),
        .out_inv(ai), .out_and2(aa), .out_nand2(an), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0), .first_fail_idx(ffi0));

    // Gates behind two register stages, checked with matching and with zero latency
    logic [63:0] l1, l2, m1, m2;
    logic [63:0] li_a = '0, la_a = '0, ln_a = '0, li_b = '0, la_b = '0, ln_b = '0;
    logic [63:0] mi_a = '0, ma_a = '0, mn_a = '0, mi_b = '0, ma_b = '0, mn_b = '0;
    logic        busyl, donel, passl, busym, donem, passm;
    logic [15:0] errl, ffil, errm, ffim;

    always_ff @(posedge clk) begin
        li_a <= ~l1; la_a <= l1 & l2; ln_a <= ~(l1 & l2);
        li_b <= li_a; la_b <= la_a; ln_b <= ln_a;
        mi_a <= ~m1; ma_a <= m1 & m2; mn_a <= ~(m1 & m2);
        mi_b <= mi_a; ma_b <= ma_a; mn_b <= mn_a;
    end

    gates_bist #(.WIDTH(64), .NUM_VECTORS(16), .LATENCY(2)) dutl (
        .clk(clk), .rst_n(rst_n), .start(startl), .inj(1'b0), .in1(l1), .in2(l2),
        .out_inv(li_b), .out_and2(la_b), .out_nand2(ln_b), .busy(busyl), .done(donel),
        .pass(passl), .err_count(errl), .first_fail_idx(ffil));

    gates_bist #(.WIDTH(64), .NUM_VECTORS(16), .LATENCY(0)) dutm (
        .clk(clk), .rst_n(rst_n), .start(startl), .inj(1'b0), .in1(m1), .in2(m2),
        .out_inv(mi_b), .out_and2(ma_b), .out_nand2(mn_b), .busy(busym), .done(donem),
        .pass(passm), .err_count(errm), .first_fail_idx(ffim));

    function automatic logic [63:0] nx(input logic [63:0] q);
        return {q[62:0], q[63] ^ q[62] ^ q[60] ^ q[59]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 16-vector run on dut0; inj pulsed during vector inj_at (negative = never)
    task automatic run0(input int inj_at);
        logic [63:0] v1, v2;
        v1 = S1;
        v2 = S2;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("run_busy_%0d", k), busy0, 1'b1);
            chk($sformatf("run_in1_%0d", k), a1, v1);
            chk($sformatf("run_in2_%0d", k), a2, v2);
            inj0 = (k == inj_at);
            @(negedge clk);
            inj0 = 1'b0;
            v1 = nx(v1);
            v2 = nx(v2);
        end
    endtask

    task automatic chk_result(input string tag, input logic [15:0] e_err,
                              input logic [15:0] e_ffi, input logic e_pass);
        chk({tag, "_done"}, done0, 1'b1);
        chk({tag, "_busy"}, busy0, 1'b0);
        chk({tag, "_err"}, err0, e_err);
        chk({tag, "_ffi"}, ffi0, e_ffi);
        chk({tag, "_pass"}, pass0, e_pass);
    endtask

    initial begin
        logic [63:0] v1, v2;
        int          n, cnt, first;

        rst_n = 1'b0; start0 = 1'b0; inj0 = 1'b0; and_stuck = 1'b0; startl = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_pass", pass0, 1'b0);
        chk("rst_err", err0, 16'd0);
        chk("rst_ffi", ffi0, 16'hFFFF);
        chk("rst_in1", a1, 64'd0);
        chk("rst_in2", a2, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean run
        run0(-1);
        chk_result("clean", 16'd0, 16'hFFFF, 1'b1);

        // Injected error on vector 5
        run0(5);
        chk_result("inj5", 16'd1, 16'd5, 1'b0);

        // and2 stuck at 0
        v1 = S1; v2 = S2; cnt = 0; first = 16'hFFFF;
        for (int k = 0; k < 16; k++) begin
            if ((v1 & v2) != 64'd0) begin
                if (cnt == 0) first = k;
                cnt++;
            end
            v1 = nx(v1);
            v2 = nx(v2);
        end
        and_stuck = 1'b1;
        run0(-1);
        and_stuck = 1'b0;
        chk_result("stuck", 16'(cnt), 16'(first), cnt == 0);

        // Registered gates: LATENCY=2 passes, LATENCY=0 fails
        startl = 1'b1;
        @(negedge clk);
        startl = 1'b0;
        n = 0;
        while (busyl && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("lat2_busy_cycles", 64'(n), 64'd18);
        chk("lat2_done", donel, 1'b1);
        chk("lat2_pass", passl, 1'b1);
        chk("lat2_err", errl, 16'd0);
        chk("lat0m_done", donem, 1'b1);
        chk("lat0m_pass", passm, 1'b0);

        // Reset during vector 7
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy_before", busy0, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy0, 1'b0);
        chk("mid_done", done0, 1'b0);
        chk("mid_pass", pass0, 1'b0);
        chk("mid_err", err0, 16'd0);
        chk("mid_ffi", ffi0, 16'hFFFF);
        chk("mid_in1", a1, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run0(-1);
        chk_result("after_rst", 16'd0, 16'hFFFF, 1'b1);

        // start held high across a whole run and into the next
        start0 = 1'b1;
        @(negedge clk);
        v1 = S1;
        v2 = S2;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("hold_busy_%0d", k), busy0, 1'b1);
            chk($sformatf("hold_in1_%0d", k), a1, v1);
            inj0 = (k == 3);
            @(negedge clk);
            inj0 = 1'b0;
            v1 = nx(v1);
            v2 = nx(v2);
        end
        chk("hold_done", done0, 1'b1);
        chk("hold_err", err0, 16'd1);
        chk("hold_ffi", ffi0, 16'd3);
        @(negedge clk);
        chk("restart_busy", busy0, 1'b1);
        chk("restart_err", err0, 16'd0);
        chk("restart_ffi", ffi0, 16'hFFFF);
        chk("restart_in1", a1, S1);
        start0 = 1'b0;
        repeat (16) @(negedge clk);
        chk_result("restart", 16'd0, 16'hFFFF, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
